hex_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the board's shared 7-segment bus (HEX/DP) across eight

---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_to_7seg.sv | 17 +
 rtl/hex_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants, state encoding and the segment table for
//               the multiplexed 7-segment display scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int NDIG  = 8;
  localparam int IDX_W = $clog2(NDIG);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic [3:0] {
    SHOW  = 4'd0,
    BLANK = 4'd1
  } state_e;

  // Active-low {g,f,e,d,c,b,a}; entry n decodes hex value n (F listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_ctrl
// Description : Eight-digit 7-segment scan scheduler with SHOW/BLANK slots,
//               frame-boundary commit of double-buffered display data and
//               leading-zero blanking. All pin outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        lzb_i,
  input  logic        load_i,
  output logic        pend_o,
  output logic        frame_o,
  output logic [6:0]  HEX,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(NDIG - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_w;

  logic [31:0]        shd_data_q, shd_data_d;
  logic [7:0]         shd_dp_q, shd_dp_d;
  logic [31:0]        act_data_q, act_data_d;
  logic [7:0]         act_dp_q, act_dp_d;
  logic               pend_q, pend_d;

  logic [NDIG-1:0]    zero_hi_w;
  logic               lzb_blank_w;
  logic [3:0]         nib_w;
  logic [6:0]         seg_w;

  logic [7:0]         an_q, an_d;
  logic [6:0]         hex_q, hex_d;
  logic               dp_q, dp_d;

  // Phase counter, slot FSM and digit index; frame pulse on digit 0's last blank cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_w = 1'b0;
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (idx_q == '0) begin
            idx_d   = IDX_FIRST;
            frame_w = 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffer: loads fill the shadow, frame boundary commits; a load on the boundary goes straight through
  always_comb begin
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    pend_d     = pend_q;
    if (load_i && frame_w) begin
      act_data_d = data_i;
      act_dp_d   = dp_i;
      pend_d     = 1'b0;
    end else if (load_i) begin
      shd_data_d = data_i;
      shd_dp_d   = dp_i;
      pend_d     = 1'b1;
    end else if (frame_w && pend_q) begin
      act_data_d = shd_data_q;
      act_dp_d   = shd_dp_q;
      pend_d     = 1'b0;
    end
  end

  // zero_hi_w[k] = nibble k and every higher nibble of the active data are zero
  always_comb begin
    zero_hi_w = '0;
    zero_hi_w[NDIG-1] = (act_data_q[4*(NDIG-1) +: 4] == 4'h0);
    for (int k = NDIG - 2; k >= 0; k--) begin
      zero_hi_w[k] = zero_hi_w[k+1] && (act_data_q[4*k +: 4] == 4'h0);
    end
  end

  assign lzb_blank_w = lzb_i && (idx_q != '0) && zero_hi_w[idx_q];
  assign nib_w       = act_data_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nib_i (nib_w),
    .seg_o (seg_w)
  );

  // Pin values for the current slot; enable and blanking inputs are used live
  always_comb begin
    an_d  = AN_OFF;
    hex_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == SHOW && en_i[idx_q]) begin
      if (lzb_blank_w) begin
        if (act_dp_q[idx_q]) begin
          an_d = ~(8'b1 << idx_q);
          dp_d = 1'b0;
        end
      end else begin
        an_d  = ~(8'b1 << idx_q);
        hex_d = seg_w;
        dp_d  = ~act_dp_q[idx_q];
      end
    end
  end

  // State, buffers and registered pin outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SHOW;
      cnt_q      <= '0;
      idx_q      <= IDX_FIRST;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      pend_q     <= 1'b0;
      an_q       <= AN_OFF;
      hex_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      hex_q      <= hex_d;
      dp_q       <= dp_d;
    end
  end

  assign pend_o  = pend_q;
  assign frame_o = frame_w;
  assign AN      = an_q;
  assign HEX     = hex_q;
  assign DP      = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_ctrl
// Description : Self-checking bench for hex_scan_ctrl (SCAN_DIV=4,
//               BLANK_CYCLES=2: slot 6 cycles, frame 48 cycles). A model
//               tracks frame position arithmetically and predicts pins,
//               frame pulse and pending flag every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  en_i;
  logic        lzb_i;
  logic        load_i;
  logic        pend_o;
  logic        frame_o;
  logic [6:0]  HEX;
  logic        DP;
  logic [7:0]  AN;

  hex_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .en_i    (en_i),
    .lzb_i   (lzb_i),
    .load_i  (load_i),
    .pend_o  (pend_o),
    .frame_o (frame_o),
    .HEX     (HEX),
    .DP      (DP),
    .AN      (AN)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // Model: position in frame of the current cycle, buffers, predicted pins {AN,HEX,DP}
  int          m_pos;
  logic [31:0] m_act, m_shd;
  logic [7:0]  m_act_dp, m_shd_dp;
  logic        m_pend;
  logic [15:0] m_out;

  function automatic logic [15:0] predict(int pos, logic [31:0] d, logic [7:0] dpm,
                                          logic [7:0] en, logic lzb);
    int k;
    logic [7:0] an_on;
    logic [3:0] nib;
    k     = 7 - pos / SLOT;
    an_on = ~(8'd1 << k);
    nib   = 4'((d >> (4 * k)) & 32'hF);
    if ((pos % SLOT) >= SD || !en[k])
      return {8'hFF, 7'h7F, 1'b1};
    if (lzb && k > 0 && (d >> (4 * k)) == 32'd0)
      return dpm[k] ? {an_on, 7'h7F, 1'b0} : {8'hFF, 7'h7F, 1'b1};
    return {an_on, seg_ref[nib], ~dpm[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at pos %0d: observed %0h expected %0h", tag, m_pos, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_act    = '0;
    m_shd    = '0;
    m_act_dp = '0;
    m_shd_dp = '0;
    m_pend   = 1'b0;
    m_out    = {8'hFF, 7'h7F, 1'b1};
  endtask

  // Check the current cycle at the falling edge, then advance model across the rising edge
  task automatic cycle();
    logic fr;
    @(negedge clk);
    fr = (m_pos == FRAME - 1);
    chk("AN", 32'(AN), 32'(m_out[15:8]));
    chk("HEX", 32'(HEX), 32'(m_out[7:1]));
    chk("DP", 32'(DP), 32'(m_out[0]));
    chk("frame_o", 32'(frame_o), 32'(fr));
    chk("pend_o", 32'(pend_o), 32'(m_pend));
    if (reset) begin
      model_reset();
    end else begin
      m_out = predict(m_pos, m_act, m_act_dp, en_i, lzb_i);
      if (load_i && fr) begin
        m_act = data_i; m_act_dp = dp_i; m_pend = 1'b0;
      end else if (load_i) begin
        m_shd = data_i; m_shd_dp = dp_i; m_pend = 1'b1;
      end else if (fr && m_pend) begin
        m_act = m_shd; m_act_dp = m_shd_dp; m_pend = 1'b0;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    data_i = d;
    dp_i   = p;
    load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    data_i = $urandom;
    dp_i   = 8'($urandom);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FRAME && m_pos != p; i++) cycle();
  endtask

  initial begin
    reset  = 1'b1;
    data_i = '0;
    dp_i   = '0;
    en_i   = 8'hFF;
    lzb_i  = 1'b0;
    load_i = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held three cycles, then free-run on reset contents
    run(3);
    reset = 1'b0;
    run(FRAME + 5);

    // Basic load, committed at the next frame boundary
    wait_pos(7);
    do_load(32'h0123_4567, 8'h00);
    run(2 * FRAME + 3);

    // Mid-frame load keeps the old frame intact until commit
    wait_pos(20);
    do_load(32'hFFFF_FFFF, 8'($urandom));
    run(FRAME + 10);

    // Load coinciding with the frame pulse bypasses the shadow
    wait_pos(FRAME - 1);
    do_load(32'h8888_8888, 8'h00);
    run(FRAME);

    // Two loads in one frame: last one wins
    wait_pos(10);
    do_load($urandom, 8'($urandom));
    wait_pos(30);
    do_load($urandom, 8'($urandom));
    run(FRAME + 20);

    // Leading-zero blanking with a decimal point on a blanked digit
    lzb_i = 1'b1;
    wait_pos(3);
    do_load(32'h0000_00D0, 8'h20);
    run(2 * FRAME);
    do_load(32'h0000_0000, 8'h00);
    run(2 * FRAME);

    // Partial enable mask, then reset pulse in digit 3's SHOW phase
    lzb_i = 1'b0;
    en_i  = 8'h0F;
    do_load($urandom, 8'($urandom));
    run(2 * FRAME);
    wait_pos(4 * SLOT + 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(FRAME + 10);

    // Randomized traffic on all live inputs
    for (int i = 0; i < 600; i++) begin
      data_i = $urandom >> $urandom_range(0, 31);
      dp_i   = 8'($urandom);
      lzb_i  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) en_i = 8'($urandom);
      load_i = ($urandom_range(0, 11) == 0);
      cycle();
    end
    load_i = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
